prim_sel_encoder: RTL and testbench
===================================

Name: prim_sel_encoder

Overview:
- Reverse direction of the primitive select decoder: takes a 32-bit primitive control word (prim_out format) and recovers the one-hot primitive select (sel_prim format, 19 bits) plus its binary index.
- Codewords live in a programmable codebook, so decoder ECO changes need only a codebook reload, not an RTL change.
- Sits on the control-word monitor path, between the control-word bus (valid/ready source) and select-consuming logic (valid/ready sink).
- 2-stage pipeline with full backpressure.

Parameters:
- N_SEL, 19, number of select lines / codebook entries.
- W_PRIM, 32, control word width.
- IDX_W, 5, index width; must satisfy 2**IDX_W >= N_SEL.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- cb_wr_en  input  1  codebook write strobe.
- cb_wr_idx  input  IDX_W  codebook entry to write.
- cb_wr_data  input  W_PRIM  codeword for that entry.
- cb_clr  input  1  invalidate all codebook entries.
- in_valid  input  1  input word valid.
- in_ready  output  1  block can accept the input word.
- in_word  input  W_PRIM  control word to encode.
- out_valid  output  1  result valid.
- out_ready  input  1  sink accepts the result.
- out_sel  output  N_SEL  one-hot select of the lowest matching entry; 0 on miss.
- out_idx  output  IDX_W  binary index of the lowest match; 0 on miss.
- out_hit  output  1  at least one valid entry matched.
- out_multi  output  1  two or more valid entries matched.
- hit_cnt  output  16  hit counter (optional feature).
- miss_cnt  output  16  miss counter (optional feature).

Behaviour:
Reset:
- Clears all codebook entries (data = 0) and all entry-valid bits.
- Flushes both pipeline stages.
- After reset: out_valid=0, out_sel=0, out_idx=0, out_hit=0, out_multi=0, in_ready=1.
- A mid-operation reset discards in-flight words; no result is produced for them.

Codebook:
- N_SEL entries, each W_PRIM data bits plus one valid bit.
- cb_wr_en at an edge writes cb_wr_data to entry cb_wr_idx and sets its valid bit.
- Writes with cb_wr_idx >= N_SEL are ignored.
- cb_clr clears all valid bits; data is retained.
- cb_clr and cb_wr_en in the same cycle: cb_clr wins and the write is dropped.
- Word accepted in the same cycle as a codebook write or clear: it is matched against the pre-update contents. The update applies from the next accepted word onward.

Stage 1 (S1):
- On accept (in_valid & in_ready), captures the match vector: bit i = valid_i & (entry_i == in_word).

Stage 2 (S2):
- Captures the priority-encoded S1 result: lowest-index match drives out_sel and out_idx.
- out_hit = |match.
- out_multi = popcount(match) >= 2.
- Miss: out_sel=0, out_idx=0, out_hit=0, out_multi=0.

Pipeline control:
- Each stage has a full flag.
- Advance into S2 when S2 is empty or out_ready=1.
- in_ready = !S1_full | S1 advancing (combinational from out_ready, no bubble).
- Latency: 2 cycles from input accept to out_valid, no stall.
- Throughput: 1 word per cycle while out_ready=1.
- While out_valid=1 and out_ready=0, all output fields hold stable and in_ready drops once S1 is full.
- in_word is not required to be stable when in_valid=0.

Optional Feature:
- Macro PRIM_SEL_STATS_EN.
- Defined:
  - hit_cnt increments on each output handshake (out_valid & out_ready) with out_hit=1; miss_cnt increments on each handshake with out_hit=0.
  - Both are 16-bit, saturate at 0xFFFF, and clear on rst.
  - cb_clr does not clear them.
- Undefined: hit_cnt and miss_cnt ports remain present, tied to 0; no counter flops.

Test Plan:
- Reset, then idle -> out_valid=0, in_ready=1, out_sel=0, out_idx=0.
- Write entry 5 = 0x0000_0021, present in_word=0x0000_0021 with out_ready=1 -> 2 cycles later out_valid=1, out_sel=0x00020, out_idx=5, out_hit=1, out_multi=0.
- Entries 3 and 7 both = 0xDEAD_BEEF, send 0xDEAD_BEEF -> out_idx=3, out_sel=0x00008, out_multi=1. Send 0x1234_5678 -> out_hit=0, out_sel=0.
- Stream 4 back-to-back matching words with out_ready held 0 for 3 cycles -> in_ready drops after 2 accepts, output holds the first result stable, all 4 results delivered in order with none lost or duplicated.
- cb_clr and cb_wr_en(idx 2) in the same cycle, then send entry 2's word -> miss. Write idx 19 -> ignored. Write entry 2 in the same cycle the word is accepted -> that word misses, the next one hits.
- Reset asserted while both stages are full -> out_valid=0 on the next cycle. With PRIM_SEL_STATS_EN: 3 hits + 1 miss handshaken -> hit_cnt=3, miss_cnt=1, and both return to 0 after rst.

Source files
------------

// File: rtl/prim_sel_encoder.sv
// Control-word to one-hot select encoder: programmable codebook match, then a
// lowest-index priority encode, in a 2-stage valid/ready pipeline. Optional
// hit/miss statistics counters are enabled with `define PRIM_SEL_STATS_EN.
module prim_sel_encoder #(
  parameter int unsigned N_SEL  = 19,
  parameter int unsigned W_PRIM = 32,
  parameter int unsigned IDX_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cb_wr_en,
  input  logic [IDX_W-1:0]  cb_wr_idx,
  input  logic [W_PRIM-1:0] cb_wr_data,
  input  logic              cb_clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W_PRIM-1:0] in_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_SEL-1:0]  out_sel,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_hit,
  output logic              out_multi,
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt
);

  logic [W_PRIM-1:0] cb_data_q [N_SEL];
  logic [W_PRIM-1:0] cb_data_d [N_SEL];
  logic [N_SEL-1:0]  cb_vld_q, cb_vld_d;

  logic              s1_full_q, s1_full_d;
  logic [N_SEL-1:0]  s1_match_q, s1_match_d;
  logic              s2_full_q, s2_full_d;
  logic [N_SEL-1:0]  s2_sel_q, s2_sel_d;
  logic [IDX_W-1:0]  s2_idx_q, s2_idx_d;
  logic              s2_hit_q, s2_hit_d;
  logic              s2_multi_q, s2_multi_d;

  logic              s2_adv_c;
  logic              accept_c;
  logic [N_SEL-1:0]  match_c;
  logic [N_SEL-1:0]  enc_sel_c;
  logic [IDX_W-1:0]  enc_idx_c;
  logic              enc_hit_c;
  logic              enc_multi_c;

  assign s2_adv_c  = !s2_full_q || out_ready;
  assign in_ready  = !s1_full_q || s2_adv_c;
  assign accept_c  = in_valid && in_ready;

  // Codebook update: clear dominates a simultaneous write; out-of-range writes drop.
  always_comb begin
    cb_data_d = cb_data_q;
    cb_vld_d  = cb_vld_q;
    if (cb_clr) begin
      cb_vld_d = '0;
    end else if (cb_wr_en && (cb_wr_idx < IDX_W'(N_SEL))) begin
      cb_data_d[cb_wr_idx] = cb_wr_data;
      cb_vld_d[cb_wr_idx]  = 1'b1;
    end
  end

  // Match against the current (pre-update) codebook contents.
  always_comb begin
    match_c = '0;
    for (int i = 0; i < N_SEL; i++) begin
      match_c[i] = cb_vld_q[i] && (cb_data_q[i] == in_word);
    end
  end

  // Lowest-index priority encode; a second match flags multi.
  always_comb begin
    enc_sel_c   = '0;
    enc_idx_c   = '0;
    enc_hit_c   = 1'b0;
    enc_multi_c = 1'b0;
    for (int i = 0; i < N_SEL; i++) begin
      if (s1_match_q[i]) begin
        if (enc_hit_c) begin
          enc_multi_c = 1'b1;
        end else begin
          enc_sel_c[i] = 1'b1;
          enc_idx_c    = IDX_W'(i);
        end
        enc_hit_c = 1'b1;
      end
    end
  end

  always_comb begin
    s1_full_d  = s1_full_q;
    s1_match_d = s1_match_q;
    s2_full_d  = s2_full_q;
    s2_sel_d   = s2_sel_q;
    s2_idx_d   = s2_idx_q;
    s2_hit_d   = s2_hit_q;
    s2_multi_d = s2_multi_q;
    if (s2_adv_c) begin
      s2_full_d = s1_full_q;
      if (s1_full_q) begin
        s2_sel_d   = enc_sel_c;
        s2_idx_d   = enc_idx_c;
        s2_hit_d   = enc_hit_c;
        s2_multi_d = enc_multi_c;
      end
      s1_full_d = 1'b0;
    end
    if (accept_c) begin
      s1_full_d  = 1'b1;
      s1_match_d = match_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_SEL; i++) cb_data_q[i] <= '0;
      cb_vld_q   <= '0;
      s1_full_q  <= 1'b0;
      s1_match_q <= '0;
      s2_full_q  <= 1'b0;
      s2_sel_q   <= '0;
      s2_idx_q   <= '0;
      s2_hit_q   <= 1'b0;
      s2_multi_q <= 1'b0;
    end else begin
      for (int i = 0; i < N_SEL; i++) cb_data_q[i] <= cb_data_d[i];
      cb_vld_q   <= cb_vld_d;
      s1_full_q  <= s1_full_d;
      s1_match_q <= s1_match_d;
      s2_full_q  <= s2_full_d;
      s2_sel_q   <= s2_sel_d;
      s2_idx_q   <= s2_idx_d;
      s2_hit_q   <= s2_hit_d;
      s2_multi_q <= s2_multi_d;
    end
  end

  assign out_valid = s2_full_q;
  assign out_sel   = s2_sel_q;
  assign out_idx   = s2_idx_q;
  assign out_hit   = s2_hit_q;
  assign out_multi = s2_multi_q;

`ifdef PRIM_SEL_STATS_EN
  logic [15:0] hit_cnt_q, hit_cnt_d;
  logic [15:0] miss_cnt_q, miss_cnt_d;

  // Saturating per-handshake hit/miss counters; untouched by codebook clear.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (s2_full_q && out_ready) begin
      if (s2_hit_q) begin
        if (hit_cnt_q != 16'hFFFF) hit_cnt_d = hit_cnt_q + 16'd1;
      end else begin
        if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_prim_sel_encoder.sv
// Scoreboard bench for prim_sel_encoder: directed scenarios plus random traffic
// checked against a codebook-search reference model.
module tb_prim_sel_encoder;
  localparam int unsigned N_SEL  = 19;
  localparam int unsigned W_PRIM = 32;
  localparam int unsigned IDX_W  = 5;

  typedef struct packed {
    logic [N_SEL-1:0] sel;
    logic [IDX_W-1:0] idx;
    logic             hit;
    logic             multi;
  } res_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              cb_wr_en;
  logic [IDX_W-1:0]  cb_wr_idx;
  logic [W_PRIM-1:0] cb_wr_data;
  logic              cb_clr;
  logic              in_valid;
  logic              in_ready;
  logic [W_PRIM-1:0] in_word;
  logic              out_valid;
  logic              out_ready;
  logic [N_SEL-1:0]  out_sel;
  logic [IDX_W-1:0]  out_idx;
  logic              out_hit;
  logic              out_multi;
  logic [15:0]       hit_cnt;
  logic [15:0]       miss_cnt;

  prim_sel_encoder #(.N_SEL(N_SEL), .W_PRIM(W_PRIM), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .cb_wr_en(cb_wr_en), .cb_wr_idx(cb_wr_idx),
    .cb_wr_data(cb_wr_data), .cb_clr(cb_clr), .in_valid(in_valid),
    .in_ready(in_ready), .in_word(in_word), .out_valid(out_valid),
    .out_ready(out_ready), .out_sel(out_sel), .out_idx(out_idx),
    .out_hit(out_hit), .out_multi(out_multi), .hit_cnt(hit_cnt),
    .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int m_hits = 0;
  int m_miss = 0;
  res_t exp_q[$];
  logic [W_PRIM-1:0] m_data [N_SEL];
  logic [N_SEL-1:0]  m_vld;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Reference: search every valid entry, count matches, report the lowest.
  function automatic res_t model(input logic [W_PRIM-1:0] w);
    res_t r;
    int   n;
    r = '0;
    n = 0;
    for (int i = 0; i < N_SEL; i++) begin
      if (m_vld[i] && m_data[i] == w) begin
        if (n == 0) begin
          r.idx = IDX_W'(i);
          r.sel = N_SEL'(1) << i;
        end
        n++;
      end
    end
    r.hit   = (n > 0);
    r.multi = (n >= 2);
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N_SEL; i++) m_data[i] = '0;
    m_vld = '0;
    exp_q.delete();
    m_hits = 0;
    m_miss = 0;
  endtask

  // One clock of stimulus; returns whether the word was accepted.
  task automatic cycle(input logic v, input logic [W_PRIM-1:0] w, input logic ordy,
                       input logic we, input int widx, input logic [W_PRIM-1:0] wd,
                       input logic clr, output logic acc);
    @(negedge clk);
    in_valid   = v;
    in_word    = w;
    out_ready  = ordy;
    cb_wr_en   = we;
    cb_wr_idx  = IDX_W'(widx);
    cb_wr_data = wd;
    cb_clr     = clr;
    #4;
    acc = v && in_ready;
    if (acc) exp_q.push_back(model(w));
    if (clr) m_vld = '0;
    else if (we && widx < N_SEL) begin
      m_data[widx] = wd;
      m_vld[widx]  = 1'b1;
    end
  endtask

  task automatic idle(input int n, input logic ordy);
    logic a;
    for (int k = 0; k < n; k++) cycle(1'b0, $urandom, ordy, 1'b0, 0, '0, 1'b0, a);
  endtask

  task automatic wr(input int idx, input logic [W_PRIM-1:0] d);
    logic a;
    cycle(1'b0, '0, 1'b1, 1'b1, idx, d, 1'b0, a);
  endtask

  task automatic send(input logic [W_PRIM-1:0] w, input logic ordy, output logic acc);
    cycle(1'b1, w, ordy, 1'b0, 0, '0, 1'b0, acc);
  endtask

  task automatic do_rst();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; cb_wr_en = 1'b0; cb_clr = 1'b0; out_ready = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
    chk("rst_flush_valid", 64'(out_valid), 64'(0));
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: pops expectations on each output handshake; checks hold during stalls.
  logic held = 1'b0;
  res_t held_v;
  initial begin
    res_t cur, e;
    forever begin
      @(negedge clk);
      #4;
      cur = {out_sel, out_idx, out_hit, out_multi};
      if (rst) begin
        held = 1'b0;
      end else begin
        if (held) chk("stall_hold", 64'({out_valid, cur}), 64'({1'b1, held_v}));
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_out", 64'(1), 64'(0));
          end else begin
            e = exp_q.pop_front();
            chk("out_result", 64'(cur), 64'(e));
            if (e.hit) m_hits++;
            else m_miss++;
          end
          held = 1'b0;
        end else if (out_valid) begin
          held   = 1'b1;
          held_v = cur;
        end else begin
          held = 1'b0;
        end
      end
    end
  end

  initial begin
    logic acc;
    int   sent;
    logic [W_PRIM-1:0] pool [8];
    rst = 1'b1; in_valid = 1'b0; in_word = '0; out_ready = 1'b1;
    cb_wr_en = 1'b0; cb_wr_idx = '0; cb_wr_data = '0; cb_clr = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #4;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_in_ready",  64'(in_ready),  64'(1));
    chk("rst_out_sel",   64'(out_sel),   64'(0));
    chk("rst_out_idx",   64'(out_idx),   64'(0));
    chk("rst_out_hit",   64'(out_hit),   64'(0));
    chk("rst_out_multi", 64'(out_multi), 64'(0));

    // Single hit and 2-cycle latency
    wr(5, 32'h0000_0021);
    send(32'h0000_0021, 1'b1, acc);
    chk("t2_accept", 64'(acc), 64'(1));
    idle(1, 1'b1);
    chk("t2_lat_s1", 64'(out_valid), 64'(0));
    idle(1, 1'b1);
    chk("t2_lat_s2", 64'(out_valid), 64'(1));
    chk("t2_sel", 64'(out_sel), 64'(19'h00020));
    chk("t2_idx", 64'(out_idx), 64'(5));
    chk("t2_hit_multi", 64'({out_hit, out_multi}), 64'(2'b10));

    // Multi-match priority, then a miss
    wr(3, 32'hDEAD_BEEF);
    wr(7, 32'hDEAD_BEEF);
    send(32'hDEAD_BEEF, 1'b1, acc);
    send(32'h1234_5678, 1'b1, acc);
    idle(1, 1'b1);
    chk("t3_idx", 64'(out_idx), 64'(3));
    chk("t3_sel", 64'(out_sel), 64'(19'h00008));
    chk("t3_multi", 64'(out_multi), 64'(1));
    idle(1, 1'b1);
    chk("t3_miss_hit", 64'(out_hit), 64'(0));
    chk("t3_miss_sel", 64'(out_sel), 64'(0));
    idle(2, 1'b1);

    // Backpressure: out_ready low for 3 cycles while streaming 4 words
    for (int i = 0; i < 4; i++) wr(i + 8, 32'h100 + i);
    sent = 0;
    for (int c = 0; c < 20 && sent < 4; c++) begin
      send(32'h100 + sent, (c >= 3), acc);
      if (c == 2) begin
        chk("stall_acc2", 64'(sent), 64'(2));
        chk("stall_in_ready", 64'(in_ready), 64'(0));
      end
      if (acc) sent++;
    end
    chk("stall_sent", 64'(sent), 64'(4));
    idle(4, 1'b1);

    // Codebook corner cases
    wr(2, 32'h5555);
    cycle(1'b0, '0, 1'b1, 1'b1, 2, 32'h5555, 1'b1, acc);
    send(32'h5555, 1'b1, acc);
    wr(19, 32'h7777);
    send(32'h7777, 1'b1, acc);
    cycle(1'b1, 32'h9999, 1'b1, 1'b1, 2, 32'h9999, 1'b0, acc);
    send(32'h9999, 1'b1, acc);
    idle(4, 1'b1);

    // Reset with both stages full
    send(32'h100, 1'b0, acc);
    send(32'h101, 1'b0, acc);
    do_rst();
    idle(1, 1'b1);
    chk("post_rst_valid", 64'(out_valid), 64'(0));

    // Random traffic over a small word pool to force hits and multi-hits
    for (int i = 0; i < 8; i++) pool[i] = 32'hA000_0000 + 32'(i);
    for (int c = 0; c < 500; c++) begin
      int r;
      logic we_r, clr_r;
      r     = int'($urandom_range(0, 99));
      we_r  = (r < 15);
      clr_r = (r >= 97);
      cycle(($urandom_range(0, 9) < 7), pool[$urandom_range(0, 7)],
            ($urandom_range(0, 3) != 0), we_r, int'($urandom_range(0, 21)),
            pool[$urandom_range(0, 7)], clr_r, acc);
    end
    idle(6, 1'b1);
    chk("drain_empty", 64'(exp_q.size()), 64'(0));
`ifdef PRIM_SEL_STATS_EN
    chk("hit_cnt", 64'(hit_cnt), 64'(m_hits));
    chk("miss_cnt", 64'(miss_cnt), 64'(m_miss));
`else
    chk("hit_cnt_tied", 64'(hit_cnt), 64'(0));
    chk("miss_cnt_tied", 64'(miss_cnt), 64'(0));
`endif
    do_rst();
    idle(1, 1'b1);
    chk("hit_cnt_rst", 64'(hit_cnt), 64'(0));
    chk("miss_cnt_rst", 64'(miss_cnt), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
